pixel_window_buffer: RTL and testbench
======================================

PIXEL_WINDOW_BUFFER -- requirements
Module: pixel_window_buffer

Interface
REQ-001 SHALL have parameter: PIXEL_W, 8, bits per pixel.
REQ-002 SHALL have port: HCLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: HRESETn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: shift_enable_r  input  1  pixel_out valid this cycle (from AHB master).
REQ-005 SHALL have port: pixel_out  input  PIXEL_W  incoming pixel byte.
REQ-006 SHALL have port: transfer_data_complete_r  input  1  AHB master finished reading current block.
REQ-007 SHALL have port: window_ack  input  1  Sobel stage consumed current window.
REQ-008 SHALL have port: clear  input  1  synchronous flush.
REQ-009 SHALL have port: window_flat  output  12*PIXEL_W  3x4 window, row-major; pixel index i=r*4+c at bits [PIXEL_W*i+PIXEL_W-1 : PIXEL_W*i].
REQ-010 SHALL have port: window_valid  output  1  all 12 pixels present.
REQ-011 SHALL have port: fill_count  output  4  pixels stored, 0..12.
REQ-012 SHALL have port: buffer_ready  output  1  high in IDLE or FILL.
REQ-013 SHALL have port: overflow_err  output  1  sticky; pixel dropped while FULL.
REQ-014 SHALL have port: short_err  output  1  sticky; block ended before 12 pixels.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, FULL, all outputs registered.
REQ-016 Priority per edge SHALL be: HRESETn low > clear > window_ack in FULL > transfer_data_complete_r > shift_enable_r.
REQ-017 IDLE: shift_enable_r -> store pixel at index 0, fill_count=1, go FILL.
REQ-018 FILL: shift_enable_r -> store pixel at index fill_count, fill_count+1; when the 12th pixel is stored, go FULL and window_valid=1 from that same edge.
REQ-019 Latency SHALL be one edge: pixel sampled at edge N is visible on window_flat after edge N.
REQ-020 FILL with transfer_data_complete_r and fill_count<12 (including same-cycle shift) SHALL: set short_err, discard the partial window, go IDLE, fill_count=0.
REQ-021 transfer_data_complete_r in IDLE or FULL SHALL be ignored.
REQ-022 FULL: window_flat SHALL remain stable while window_valid=1.
REQ-023 FULL, window_ack without shift: go IDLE, window_valid=0, fill_count=0.
REQ-024 FULL, window_ack with shift_enable_r in the same cycle: store pixel at index 0, fill_count=1, go FILL, window_valid=0.
REQ-025 FULL, shift_enable_r without window_ack: drop pixel, set overflow_err; window unchanged.
REQ-026 window_ack outside FULL SHALL be ignored.
REQ-027 clear SHALL return to IDLE: fill_count=0, window_valid=0, window_flat=0, both error flags=0.
REQ-028 Error flags SHALL clear only on reset or clear.
REQ-029 fill_count SHALL never exceed 12.

Reset
REQ-030 HRESETn low SHALL immediately force: IDLE, window_flat=0, window_valid=0, fill_count=0, buffer_ready=1, overflow_err=0, short_err=0.
REQ-031 Reset asserted mid-fill SHALL discard all stored pixels; the first shift after release stores at index 0.

Verification
REQ-032 12 shifts of 3E,9D,13,E1,14,A9,33,64,2F,7F,FF,4A -> byte0=3E, byte3=E1, byte11=4A; fill_count=12, window_valid=1, buffer_ready=0 after the 12th edge.
REQ-033 Full window, then window_ack for one cycle -> window_valid=0, fill_count=0, state IDLE on the next edge.
REQ-034 Full window, then shift of 10 with no ack -> overflow_err=1, byte0 still 3E, fill_count=12.
REQ-035 5 shifts (10,25,E0,A9,2F), then transfer_data_complete_r -> short_err=1, fill_count=0, window_valid=0.
REQ-036 Full window, then window_ack plus shift of B1 in the same cycle -> byte0=B1, fill_count=1, window_valid=0, no overflow_err.
REQ-037 7 shifts, then HRESETn pulsed low between edges -> all outputs at reset values immediately; the next shift of 7A lands at byte0.

Source files
------------

// File: rtl/pixel_window_buffer.sv
// Collects a 3x4 pixel window from a byte stream and holds it for a downstream
// consumer. IDLE -> FILL -> FULL handshake with sticky overflow and short-block flags.
module pixel_window_buffer #(
   parameter int PIXEL_W = 8
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 shift_enable_r,
   input  logic [PIXEL_W-1:0]   pixel_out,
   input  logic                 transfer_data_complete_r,
   input  logic                 window_ack,
   input  logic                 clear,
   output logic [12*PIXEL_W-1:0] window_flat,
   output logic                 window_valid,
   output logic [3:0]           fill_count,
   output logic                 buffer_ready,
   output logic                 overflow_err,
   output logic                 short_err
);

   localparam int NPIX  = 12;
   localparam int WIN_W = NPIX * PIXEL_W;

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

   state_t             state_q, state_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic               ready_q, ready_d;
   logic               ovf_q, ovf_d;
   logic               short_q, short_d;

   function automatic logic [WIN_W-1:0] put_pixel(input logic [WIN_W-1:0] w,
                                                  input logic [3:0]       idx,
                                                  input logic [PIXEL_W-1:0] p);
      logic [WIN_W-1:0] r;
      r = w;
      for (int i = 0; i < NPIX; i++) begin
         if (idx == 4'(i)) r[i*PIXEL_W +: PIXEL_W] = p;
      end
      return r;
   endfunction

   // Priority: clear > ack (FULL only) > block complete (FILL only) > shift.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      short_d = short_q;
      if (clear) begin
         state_d = IDLE;
         win_d   = '0;
         cnt_d   = 4'd0;
         valid_d = 1'b0;
         ovf_d   = 1'b0;
         short_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (shift_enable_r) begin
                  win_d   = put_pixel(win_q, 4'd0, pixel_out);
                  cnt_d   = 4'd1;
                  state_d = FILL;
               end
            end
            FILL: begin
               if (transfer_data_complete_r) begin
                  short_d = 1'b1;
                  win_d   = '0;
                  cnt_d   = 4'd0;
                  state_d = IDLE;
               end else if (shift_enable_r) begin
                  win_d = put_pixel(win_q, cnt_q, pixel_out);
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'(NPIX - 1)) begin
                     state_d = FULL;
                     valid_d = 1'b1;
                  end
               end
            end
            FULL: begin
               if (window_ack) begin
                  valid_d = 1'b0;
                  if (shift_enable_r) begin
                     win_d   = put_pixel(win_q, 4'd0, pixel_out);
                     cnt_d   = 4'd1;
                     state_d = FILL;
                  end else begin
                     cnt_d   = 4'd0;
                     state_d = IDLE;
                  end
               end else if (shift_enable_r) begin
                  ovf_d = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 4'd0;
               valid_d = 1'b0;
            end
         endcase
      end
      ready_d = (state_d != FULL);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         win_q   <= '0;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         ovf_q   <= 1'b0;
         short_q <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         ovf_q   <= ovf_d;
         short_q <= short_d;
      end
   end

   assign window_flat  = win_q;
   assign window_valid = valid_q;
   assign fill_count   = cnt_q;
   assign buffer_ready = ready_q;
   assign overflow_err = ovf_q;
   assign short_err    = short_q;

endmodule

// File: tb/tb_pixel_window_buffer.sv
// Directed bench for pixel_window_buffer: stimulus pushes expected states into a
// queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_pixel_window_buffer;

   logic        HCLK;
   logic        HRESETn;
   logic        shift_enable_r;
   logic [7:0]  pixel_out;
   logic        transfer_data_complete_r;
   logic        window_ack;
   logic        clear;
   logic [95:0] window_flat;
   logic        window_valid;
   logic [3:0]  fill_count;
   logic        buffer_ready;
   logic        overflow_err;
   logic        short_err;

   pixel_window_buffer #(.PIXEL_W(8)) dut (
      .HCLK                     (HCLK),
      .HRESETn                  (HRESETn),
      .shift_enable_r           (shift_enable_r),
      .pixel_out                (pixel_out),
      .transfer_data_complete_r (transfer_data_complete_r),
      .window_ack               (window_ack),
      .clear                    (clear),
      .window_flat              (window_flat),
      .window_valid             (window_valid),
      .fill_count               (fill_count),
      .buffer_ready             (buffer_ready),
      .overflow_err             (overflow_err),
      .short_err                (short_err)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      string       name;
      logic [95:0] flat;
      logic [11:0] bmask;
      logic [3:0]  cnt;
      logic        valid;
      logic        ready;
      logic        ovf;
      logic        shrt;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [95:0] ew;

   task automatic cmp(input string name, input string field,
                      input logic [95:0] act, input logic [95:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s.%s got=%0h want=%0h", name, field, act, want);
      end
   endtask

   // Monitor: one expectation per cycle, compared at the falling edge.
   initial begin
      exp_t        e;
      logic [95:0] m;
      forever begin
         @(negedge HCLK);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            m = '0;
            for (int i = 0; i < 12; i++) if (e.bmask[i]) m[8*i +: 8] = 8'hFF;
            cmp(e.name, "flat",  window_flat & m, e.flat & m);
            cmp(e.name, "cnt",   96'(fill_count),   96'(e.cnt));
            cmp(e.name, "valid", 96'(window_valid), 96'(e.valid));
            cmp(e.name, "ready", 96'(buffer_ready), 96'(e.ready));
            cmp(e.name, "ovf",   96'(overflow_err), 96'(e.ovf));
            cmp(e.name, "short", 96'(short_err),    96'(e.shrt));
         end
      end
   end

   task automatic expect_st(input string name, input logic [3:0] cnt, input logic v,
                            input logic r, input logic o, input logic s,
                            input logic [11:0] m);
      exp_t e;
      e.name = name; e.flat = ew; e.bmask = m; e.cnt = cnt;
      e.valid = v; e.ready = r; e.ovf = o; e.shrt = s;
      sb.push_back(e);
   endtask

   task automatic step(input logic sh, input logic [7:0] px, input logic tdc,
                       input logic ack, input logic clr);
      shift_enable_r = sh; pixel_out = px; transfer_data_complete_r = tdc;
      window_ack = ack; clear = clr;
      @(posedge HCLK);
      #1;
      shift_enable_r = 1'b0; pixel_out = 8'h00; transfer_data_complete_r = 1'b0;
      window_ack = 1'b0; clear = 1'b0;
   endtask

   logic [7:0] pix [12];
   logic [7:0] pix5 [5];

   initial begin
      pix  = '{8'h3E, 8'h9D, 8'h13, 8'hE1, 8'h14, 8'hA9,
               8'h33, 8'h64, 8'h2F, 8'h7F, 8'hFF, 8'h4A};
      pix5 = '{8'h10, 8'h25, 8'hE0, 8'hA9, 8'h2F};
      HRESETn = 1'b0;
      shift_enable_r = 1'b0; pixel_out = 8'h00; transfer_data_complete_r = 1'b0;
      window_ack = 1'b0; clear = 1'b0;
      ew = '0;
      #1;
      expect_st("reset", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);
      @(negedge HCLK);
      #2;
      HRESETn = 1'b1;

      for (int i = 0; i < 12; i++) begin
         step(1'b1, pix[i], 1'b0, 1'b0, 1'b0);
         ew[8*i +: 8] = pix[i];
         expect_st($sformatf("fill%0d", i + 1), 4'(i + 1), (i == 11), (i != 11),
                   1'b0, 1'b0, 12'((1 << (i + 1)) - 1));
      end

      step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
      expect_st("overflow", 4'd12, 1'b1, 1'b0, 1'b1, 1'b0, 12'hFFF);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      expect_st("tdc_in_full", 4'd12, 1'b1, 1'b0, 1'b1, 1'b0, 12'hFFF);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      expect_st("ack", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      expect_st("ack_in_idle", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      ew = '0;
      expect_st("clear", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);

      for (int i = 0; i < 12; i++) begin
         step(1'b1, pix[i], 1'b0, 1'b0, 1'b0);
         ew[8*i +: 8] = pix[i];
      end
      expect_st("refill", 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF);
      step(1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
      ew[7:0] = 8'hB1;
      expect_st("ack_shift", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h001);

      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      ew = '0;
      expect_st("clear2", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, pix5[i], 1'b0, 1'b0, 1'b0);
         ew[8*i +: 8] = pix5[i];
      end
      expect_st("fill5", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 12'h01F);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      expect_st("short", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      expect_st("tdc_in_idle", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      ew[7:0] = 8'h55;
      expect_st("fill1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001);
      step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
      expect_st("tdc_beats_shift", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
      ew = '0;
      expect_st("clear_beats_shift", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);

      for (int i = 0; i < 7; i++) begin
         step(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
         ew[8*i +: 8] = 8'(i + 1);
      end
      expect_st("fill7", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 12'h07F);
      @(negedge HCLK);
      #1;
      @(posedge HCLK);
      #2;
      HRESETn = 1'b0;
      ew = '0;
      #1;
      expect_st("async_reset", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);
      @(negedge HCLK);
      #1;
      HRESETn = 1'b1;
      step(1'b1, 8'h7A, 1'b0, 1'b0, 1'b0);
      ew[7:0] = 8'h7A;
      expect_st("after_reset", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);

      for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge HCLK);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
